// File: rtl/dvp_cam_tx.sv
// DVP camera transmitter: replays a bgr565 pixel stream as an 8-bit camera bus with
// pclk = clk/2, vsync/href framing and high byte first. All vertical regions must be >= 1 line.
module dvp_cam_tx #(
    parameter int H_ACTIVE  = 640,
    parameter int H_BLANK   = 144,
    parameter int V_ACTIVE  = 480,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 16,
    parameter int V_FRONT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        cmos_pclk,
    output logic        cmos_vsync,
    output logic        cmos_href,
    output logic [7:0]  cmos_db,
    output logic        frame_done,
    output logic        busy,
    output logic        underflow,
    output logic [15:0] frame_cnt
);

    localparam int LINE_SLOTS  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LINES = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
    localparam int SW          = $clog2(LINE_SLOTS + 1);
    localparam int LW          = $clog2(FRAME_LINES + 1);

    localparam logic [SW-1:0] LAST_SLOT  = SW'(LINE_SLOTS - 1);
    localparam logic [SW-1:0] HREF_SLOTS = SW'(2 * H_ACTIVE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VBACK  = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_VFRONT = 3'd4;

    logic [2:0]    state;
    logic [2:0]    nxt_state;
    logic          phase;
    logic [SW-1:0] slot_cnt;
    logic [SW-1:0] nxt_slot;
    logic [LW-1:0] line_cnt;
    logic [LW-1:0] nxt_line;
    logic [LW-1:0] region_last;
    logic          last_slot;
    logic          last_line;
    logic          adv;
    logic          nxt_href;
    logic          nxt_hi;
    logic          frame_end_next;
    logic [7:0]    pix_lo;

    always_comb begin
        case (state)
            S_VSYNC:  region_last = LW'(VSYNC_LEN - 1);
            S_VBACK:  region_last = LW'(V_BACK - 1);
            S_ACTIVE: region_last = LW'(V_ACTIVE - 1);
            default:  region_last = LW'(V_FRONT - 1);
        endcase
    end

    // Position of the slot that follows the current one; applied at the end of slot cycle 1.
    always_comb begin
        last_slot = (slot_cnt == LAST_SLOT);
        last_line = (line_cnt == region_last);
        nxt_state = state;
        nxt_slot  = slot_cnt;
        nxt_line  = line_cnt;
        if (state == S_IDLE) begin
            nxt_state = en ? S_VSYNC : S_IDLE;
            nxt_slot  = '0;
            nxt_line  = '0;
        end else if (!last_slot) begin
            nxt_slot = slot_cnt + SW'(1);
        end else begin
            nxt_slot = '0;
            if (!last_line) begin
                nxt_line = line_cnt + LW'(1);
            end else begin
                nxt_line = '0;
                case (state)
                    S_VSYNC:  nxt_state = S_VBACK;
                    S_VBACK:  nxt_state = S_ACTIVE;
                    S_ACTIVE: nxt_state = S_VFRONT;
                    default:  nxt_state = en ? S_VSYNC : S_IDLE;
                endcase
            end
        end
    end

    assign adv            = (state == S_IDLE) ? en : phase;
    assign nxt_href       = (nxt_state == S_ACTIVE) && (nxt_slot < HREF_SLOTS);
    assign nxt_hi         = nxt_href && !nxt_slot[0];
    assign pix_ready      = phase && nxt_hi;
    assign frame_end_next = (state == S_VFRONT) && last_line && last_slot && !phase;
    assign cmos_pclk      = phase;
    assign busy           = (state != S_IDLE);

    // Bus outputs are registered at slot boundaries so they are stable across the pclk rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            slot_cnt   <= '0;
            line_cnt   <= '0;
            cmos_vsync <= 1'b0;
            cmos_href  <= 1'b0;
            cmos_db    <= 8'h00;
            pix_lo     <= 8'h00;
            frame_done <= 1'b0;
            frame_cnt  <= 16'h0000;
            underflow  <= 1'b0;
        end else begin
            phase      <= (state == S_IDLE) ? 1'b0 : ~phase;
            frame_done <= frame_end_next;
            if (frame_end_next) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (adv) begin
                state      <= nxt_state;
                slot_cnt   <= nxt_slot;
                line_cnt   <= nxt_line;
                cmos_vsync <= (nxt_state == S_VSYNC);
                cmos_href  <= nxt_href;
                if (!nxt_href) begin
                    cmos_db <= 8'h00;
                end else if (nxt_hi) begin
                    cmos_db <= pix_valid ? pix_data[15:8] : 8'h00;
                end else begin
                    cmos_db <= pix_lo;
                end
            end
            // A starved pixel goes out as 0x0000 and is remembered until reset.
            if (pix_ready) begin
                pix_lo <= pix_valid ? pix_data[7:0] : 8'h00;
                if (!pix_valid) begin
                    underflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvp_cam_tx.sv
// Randomized bench for dvp_cam_tx: expected bus values come from frame-position
// arithmetic (cycle -> line/slot) and a table of the pixels offered to the block.
module tb_dvp_cam_tx;

    localparam int H_ACTIVE      = 4;
    localparam int H_BLANK       = 2;
    localparam int V_ACTIVE      = 2;
    localparam int VSYNC_LEN     = 1;
    localparam int V_BACK        = 1;
    localparam int V_FRONT       = 1;
    localparam int LINE_CLK      = 2 * (2 * H_ACTIVE + H_BLANK);
    localparam int FRAME_LINES   = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
    localparam int FRAME_CLK     = LINE_CLK * FRAME_LINES;
    localparam int PIX_PER_FRAME = H_ACTIVE * V_ACTIVE;
    localparam int FIRST_ACTIVE  = VSYNC_LEN + V_BACK;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        cmos_pclk;
    logic        cmos_vsync;
    logic        cmos_href;
    logic [7:0]  cmos_db;
    logic        frame_done;
    logic        busy;
    logic        underflow;
    logic [15:0] frame_cnt;

    dvp_cam_tx #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .VSYNC_LEN(VSYNC_LEN),
        .V_BACK   (V_BACK),
        .V_FRONT  (V_FRONT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .cmos_pclk (cmos_pclk),
        .cmos_vsync(cmos_vsync),
        .cmos_href (cmos_href),
        .cmos_db   (cmos_db),
        .frame_done(frame_done),
        .busy      (busy),
        .underflow (underflow),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] pix [0:63];
    logic        val [0:63];
    int          run_k;
    int          cons;
    int          cur_t;
    logic        uf_state;
    logic        exp_pclk, exp_vsync, exp_href, exp_ready, exp_done, exp_uf;
    logic [7:0]  exp_db;
    logic [15:0] exp_cnt;

    function automatic logic line_active(input int line);
        return (line >= FIRST_ACTIVE) && (line < FIRST_ACTIVE + V_ACTIVE);
    endfunction

    // True when frame cycle t lies in a slot carrying a pixel's high byte.
    function automatic logic is_hi_slot(input int t);
        int slot;
        slot = (t % LINE_CLK) / 2;
        return line_active(t / LINE_CLK) && (slot < 2 * H_ACTIVE) && (slot % 2 == 0);
    endfunction

    task automatic do_reset();
        en = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'h0000;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        uf_state = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_run(input int drop_pct, input bit demo);
        for (int i = 0; i < 64; i++) begin
            pix[i] = 16'($urandom);
            val[i] = ($urandom_range(99) >= 32'(drop_pct));
        end
        if (demo) begin
            pix[0] = 16'h1234;
            pix[1] = 16'hABCD;
        end
        run_k = -1;
        cons = 0;
        uf_state = 1'b0;
        en = 1'b1;
    endtask

    // Advance one clock, compute expectations for the new cycle, then drive the source.
    task automatic step();
        int t, f, line, slot, g;
        logic [15:0] pv;
        @(posedge clk);
        @(negedge clk);
        run_k++;
        t = run_k % FRAME_CLK;
        f = run_k / FRAME_CLK;
        cur_t = t;
        line = t / LINE_CLK;
        slot = (t % LINE_CLK) / 2;
        exp_pclk  = (t % 2) == 1;
        exp_vsync = line < VSYNC_LEN;
        exp_href  = line_active(line) && (slot < 2 * H_ACTIVE);
        exp_db    = 8'h00;
        if (exp_href) begin
            g = f * PIX_PER_FRAME + (line - FIRST_ACTIVE) * H_ACTIVE + slot / 2;
            pv = val[g] ? pix[g] : 16'h0000;
            exp_db = (slot % 2 == 0) ? pv[15:8] : pv[7:0];
        end
        exp_ready = exp_pclk && (t + 1 < FRAME_CLK) && is_hi_slot(t + 1);
        exp_done  = (t == FRAME_CLK - 1);
        exp_cnt   = 16'(f + (exp_done ? 1 : 0));
        exp_uf    = uf_state;
        if (exp_ready) begin
            pix_data  = pix[cons];
            pix_valid = val[cons];
            if (!val[cons]) uf_state = 1'b1;
            cons++;
        end else begin
            pix_data  = 16'($urandom);
            pix_valid = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors += 9;
        if (cmos_pclk !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pclk got %b want 0", cmos_pclk); end
        if (cmos_vsync !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_vsync got %b want 0", cmos_vsync); end
        if (cmos_href !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_href got %b want 0", cmos_href); end
        if (cmos_db !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_db got %h want 00", cmos_db); end
        if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_ready got %b want 0", pix_ready); end
        if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done got %b want 0", frame_done); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_busy got %b want 0", busy); end
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_uf got %b want 0", underflow); end
        if (frame_cnt !== 16'h0000) begin miscompares++; $display("[TB] FAIL rst_cnt got %h want 0000", frame_cnt); end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pix_valid = 1'($urandom);
            vectors += 3;
            if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy c=%0d got %b want 0", i, busy); end
            if (cmos_pclk !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_pclk c=%0d got %b want 0", i, cmos_pclk); end
            if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_ready c=%0d got %b want 0", i, pix_ready); end
        end
    endtask

    task automatic test_timing();
        int vs_cycles = 0;
        int ready_cycles = 0;
        int first_href = -1;
        $display("[TB] timing and data over two back-to-back frames");
        do_reset();
        start_run(0, 1'b1);
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            step();
            vectors += 9;
            if (cmos_pclk !== exp_pclk) begin miscompares++; $display("[TB] FAIL pclk k=%0d got %b want %b", run_k, cmos_pclk, exp_pclk); end
            if (cmos_vsync !== exp_vsync) begin miscompares++; $display("[TB] FAIL vsync k=%0d got %b want %b", run_k, cmos_vsync, exp_vsync); end
            if (cmos_href !== exp_href) begin miscompares++; $display("[TB] FAIL href k=%0d got %b want %b", run_k, cmos_href, exp_href); end
            if (cmos_db !== exp_db) begin miscompares++; $display("[TB] FAIL db k=%0d got %h want %h", run_k, cmos_db, exp_db); end
            if (pix_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL ready k=%0d got %b want %b", run_k, pix_ready, exp_ready); end
            if (frame_done !== exp_done) begin miscompares++; $display("[TB] FAIL done k=%0d got %b want %b", run_k, frame_done, exp_done); end
            if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy k=%0d got %b want 1", run_k, busy); end
            if (frame_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL cnt k=%0d got %0d want %0d", run_k, frame_cnt, exp_cnt); end
            if (underflow !== exp_uf) begin miscompares++; $display("[TB] FAIL uf k=%0d got %b want %b", run_k, underflow, exp_uf); end
            if (cmos_vsync === 1'b1) vs_cycles++;
            if (pix_ready === 1'b1) ready_cycles++;
            if (cmos_href === 1'b1 && first_href < 0) first_href = i;
        end
        vectors += 3;
        if (vs_cycles != 2 * VSYNC_LEN * LINE_CLK) begin miscompares++; $display("[TB] FAIL vsync_len got %0d want %0d", vs_cycles, 2 * VSYNC_LEN * LINE_CLK); end
        if (ready_cycles != 2 * PIX_PER_FRAME) begin miscompares++; $display("[TB] FAIL ready_pulses got %0d want %0d", ready_cycles, 2 * PIX_PER_FRAME); end
        if (first_href != FIRST_ACTIVE * LINE_CLK) begin miscompares++; $display("[TB] FAIL href_start got %0d want %0d", first_href, FIRST_ACTIVE * LINE_CLK); end
    endtask

    task automatic test_underflow();
        $display("[TB] underflow: third pixel starved, random starvation in second frame");
        do_reset();
        start_run(0, 1'b1);
        val[2] = 1'b0;
        for (int i = PIX_PER_FRAME; i < 2 * PIX_PER_FRAME; i++) val[i] = ($urandom_range(3) != 0);
        for (int i = 0; i < 2 * FRAME_CLK; i++) begin
            step();
            vectors += 4;
            if (cmos_href !== exp_href) begin miscompares++; $display("[TB] FAIL uf_href k=%0d got %b want %b", run_k, cmos_href, exp_href); end
            if (cmos_db !== exp_db) begin miscompares++; $display("[TB] FAIL uf_db k=%0d got %h want %h", run_k, cmos_db, exp_db); end
            if (pix_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL uf_ready k=%0d got %b want %b", run_k, pix_ready, exp_ready); end
            if (underflow !== exp_uf) begin miscompares++; $display("[TB] FAIL uf_flag k=%0d got %b want %b", run_k, underflow, exp_uf); end
        end
        vectors++;
        if (underflow !== 1'b1) begin miscompares++; $display("[TB] FAIL uf_sticky got %b want 1", underflow); end
    endtask

    task automatic test_enable_drop();
        $display("[TB] enable dropped mid-active: frame completes, then idle");
        do_reset();
        start_run(0, 1'b0);
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            vectors += 6;
            if (cmos_vsync !== exp_vsync) begin miscompares++; $display("[TB] FAIL en_vsync k=%0d got %b want %b", run_k, cmos_vsync, exp_vsync); end
            if (cmos_href !== exp_href) begin miscompares++; $display("[TB] FAIL en_href k=%0d got %b want %b", run_k, cmos_href, exp_href); end
            if (cmos_db !== exp_db) begin miscompares++; $display("[TB] FAIL en_db k=%0d got %h want %h", run_k, cmos_db, exp_db); end
            if (frame_done !== exp_done) begin miscompares++; $display("[TB] FAIL en_done k=%0d got %b want %b", run_k, frame_done, exp_done); end
            if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL en_busy k=%0d got %b want 1", run_k, busy); end
            if (frame_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL en_cnt k=%0d got %0d want %0d", run_k, frame_cnt, exp_cnt); end
            if (cur_t == 50) en = 1'b0;
        end
        for (int i = 0; i < 3 * FRAME_CLK; i++) begin
            @(posedge clk);
            @(negedge clk);
            pix_data  = 16'($urandom);
            pix_valid = 1'($urandom);
            vectors += 7;
            if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL post_busy c=%0d got %b want 0", i, busy); end
            if (cmos_vsync !== 1'b0) begin miscompares++; $display("[TB] FAIL post_vsync c=%0d got %b want 0", i, cmos_vsync); end
            if (cmos_pclk !== 1'b0) begin miscompares++; $display("[TB] FAIL post_pclk c=%0d got %b want 0", i, cmos_pclk); end
            if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL post_ready c=%0d got %b want 0", i, pix_ready); end
            if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL post_done c=%0d got %b want 0", i, frame_done); end
            if (frame_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL post_cnt c=%0d got %0d want 1", i, frame_cnt); end
            if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL post_uf c=%0d got %b want 0", i, underflow); end
        end
    endtask

    task automatic test_reset_midline();
        $display("[TB] asynchronous reset during href, then restart");
        do_reset();
        start_run(0, 1'b0);
        for (int i = 0; i < FIRST_ACTIVE * LINE_CLK + 6; i++) step();
        vectors++;
        if (cmos_href !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_rst_href got %b want 1", cmos_href); end
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        vectors += 9;
        if (cmos_pclk !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_pclk got %b want 0", cmos_pclk); end
        if (cmos_vsync !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_vsync got %b want 0", cmos_vsync); end
        if (cmos_href !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_href got %b want 0", cmos_href); end
        if (cmos_db !== 8'h00) begin miscompares++; $display("[TB] FAIL mid_db got %h want 00", cmos_db); end
        if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ready got %b want 0", pix_ready); end
        if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_done got %b want 0", frame_done); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_busy got %b want 0", busy); end
        if (underflow !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_uf got %b want 0", underflow); end
        if (frame_cnt !== 16'h0000) begin miscompares++; $display("[TB] FAIL mid_cnt got %h want 0000", frame_cnt); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        uf_state = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors += 2;
            if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rel_busy c=%0d got %b want 0", i, busy); end
            if (cmos_vsync !== 1'b0) begin miscompares++; $display("[TB] FAIL rel_vsync c=%0d got %b want 0", i, cmos_vsync); end
        end
        start_run(0, 1'b0);
        for (int i = 0; i < FRAME_CLK; i++) begin
            step();
            vectors += 8;
            if (cmos_pclk !== exp_pclk) begin miscompares++; $display("[TB] FAIL re_pclk k=%0d got %b want %b", run_k, cmos_pclk, exp_pclk); end
            if (cmos_vsync !== exp_vsync) begin miscompares++; $display("[TB] FAIL re_vsync k=%0d got %b want %b", run_k, cmos_vsync, exp_vsync); end
            if (cmos_href !== exp_href) begin miscompares++; $display("[TB] FAIL re_href k=%0d got %b want %b", run_k, cmos_href, exp_href); end
            if (cmos_db !== exp_db) begin miscompares++; $display("[TB] FAIL re_db k=%0d got %h want %h", run_k, cmos_db, exp_db); end
            if (pix_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL re_ready k=%0d got %b want %b", run_k, pix_ready, exp_ready); end
            if (frame_done !== exp_done) begin miscompares++; $display("[TB] FAIL re_done k=%0d got %b want %b", run_k, frame_done, exp_done); end
            if (frame_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL re_cnt k=%0d got %0d want %0d", run_k, frame_cnt, exp_cnt); end
            if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL re_busy k=%0d got %b want 1", run_k, busy); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout reached without finishing, %0d miscompares so far", miscompares);
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        pix_valid = 1'b0;
        pix_data = 16'h0000;
        uf_state = 1'b0;
        run_k = -1;
        cons = 0;
        cur_t = 0;
        test_reset();
        test_timing();
        test_underflow();
        test_enable_drop();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dvp_cam_tx.md
DVP_CAM_TX -- requirements
Module: dvp_cam_tx

Interface
REQ-001 The block SHALL have these parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, active pixels per line
- H_BLANK, 144, href-low byte slots after each active line
- V_ACTIVE, 480, active lines per frame
- VSYNC_LEN, 4, lines with cmos_vsync high
- V_BACK, 16, blank lines after vsync
- V_FRONT, 8, blank lines after the active region
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, input, 1, sole clock
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, frame generation enable
- pix_valid, input, 1, source pixel available
- pix_data, input, 16, source pixel, bgr565
- pix_ready, output, 1, pixel consumed this cycle
- cmos_pclk, output, 1, pixel clock, clk/2
- cmos_vsync, output, 1, frame sync, active high
- cmos_href, output, 1, line valid
- cmos_db, output, 8, byte data
- frame_done, output, 1, one-cycle end-of-frame pulse
- busy, output, 1, frame in progress
- underflow, output, 1, sticky pixel-starvation flag
- frame_cnt, output, 16, completed frames
REQ-003 One clock domain SHALL be used: clk; reset SHALL be asynchronous, active-low, on rst_n.

Function
REQ-004 A byte slot SHALL be 2 clk cycles; cmos_pclk SHALL be 0 in slot cycle 0 and 1 in slot cycle 1; it SHALL be held at 0 in IDLE.
REQ-005 cmos_vsync, cmos_href and cmos_db SHALL change only at slot cycle 0, so a sink sampling on the cmos_pclk rising edge sees stable values.
REQ-006 A line SHALL be 2*H_ACTIVE+H_BLANK slots long; a frame SHALL be VSYNC_LEN+V_BACK+V_ACTIVE+V_FRONT lines long.
REQ-007 The states SHALL be IDLE, VSYNC, VBACK, ACTIVE and VFRONT, with these transitions:
- IDLE->VSYNC on the clk edge that samples en=1
- VSYNC->VBACK after VSYNC_LEN lines
- VBACK->ACTIVE after V_BACK lines
- ACTIVE->VFRONT after V_ACTIVE lines
- VFRONT->VSYNC at frame end if en=1, otherwise VFRONT->IDLE
REQ-008 In VSYNC, cmos_vsync SHALL be 1 and cmos_href 0; in all other states cmos_vsync SHALL be 0.
REQ-009 In ACTIVE, cmos_href SHALL be 1 for the first 2*H_ACTIVE slots of each line and 0 for the H_BLANK slots.
REQ-010 Each pixel SHALL be sent high byte (pix_data[15:8]) then low byte (pix_data[7:0]); cmos_db SHALL be 0 whenever cmos_href=0.
REQ-011 pix_ready SHALL be 1 for exactly one clk: slot cycle 1 of the slot preceding each high-byte slot. pix_data SHALL be latched in that cycle when pix_valid=1.
REQ-012 If pix_valid=0 while pix_ready=1, the pixel SHALL be sent as 0x0000 and underflow SHALL be set; it stays set until reset.
REQ-013 pix_ready SHALL be 0 outside ACTIVE line regions; pix_valid SHALL be ignored there and SHALL NOT set underflow.
REQ-014 frame_done SHALL pulse for one clk in the final clk of the last VFRONT slot; frame_cnt SHALL increment in the same cycle, wrapping 0xFFFF->0.
REQ-015 busy SHALL be 1 in every state except IDLE.
REQ-016 en deasserted mid-frame SHALL NOT truncate the frame; it takes effect only at frame end (REQ-007).
REQ-017 Line and slot counters SHALL be sized for the parameter ranges used, with no overflow at the defaults.

Reset
REQ-018 rst_n=0 SHALL immediately force all of the following, asynchronously, at any point including mid-line:
- state IDLE
- cmos_pclk=0, cmos_vsync=0, cmos_href=0, cmos_db=0
- pix_ready=0, frame_done=0, busy=0, underflow=0, frame_cnt=0
- all counters cleared
REQ-019 After rst_n rises, the block SHALL remain in IDLE until en=1 is sampled.

Verification
Bench parameters for all scenarios: H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, VSYNC_LEN=1, V_BACK=1, V_FRONT=1 (line=10 slots=20 clk, frame=100 clk).
REQ-020 Timing: en held 1, pix_valid=1 -> cmos_vsync high for 20 clk; first cmos_href high 40 clk after the vsync rise, lasting 16 clk; frame_done every 100 clk.
REQ-021 Data: pixels 0x1234, 0xABCD, ... -> cmos_db sampled on cmos_pclk rise reads 0x12, 0x34, 0xAB, 0xCD in order; 8 pix_ready pulses per frame.
REQ-022 Underflow: pix_valid=0 for the 3rd pixel -> bytes 0x00, 0x00 sent at that position; underflow=1 and stays 1.
REQ-023 Enable: en dropped mid-ACTIVE -> frame completes, frame_done pulses, busy=0 next cycle, frame_cnt=1, no further vsync.
REQ-024 Reset: rst_n pulsed low mid-href -> all outputs 0 in the same cycle; restart with en=1 gives a full frame beginning with VSYNC.
